// File: rtl/common_defines.sv
`default_nettype none
// ============================================================================
// common_defines
//   Sound clip IDs, the shared-ROM clip table and the silent PWM level.
//   Revision: 1.0
// ============================================================================
package common_defines;

   localparam int SND_ADDR_W = 15;
   localparam int SND_DATA_W = 8;
   localparam int SND_NUM    = 3;

   typedef enum logic [1:0] {
      SND_CHOMP = 2'd0,
      SND_SIREN = 2'd1,
      SND_DEATH = 2'd2
   } sound_id_t;

   localparam logic [SND_DATA_W-1:0] IDLE_LEVEL = 8'h80;

   // Indexed by sound ID; clips are packed back to back in the ROM
   localparam logic [SND_ADDR_W-1:0] CLIP_START [SND_NUM] = '{15'd0,    15'd5736, 15'd6760};
   localparam logic [SND_ADDR_W-1:0] CLIP_LEN   [SND_NUM] = '{15'd5736, 15'd1024, 15'd12000};
   localparam logic                  CLIP_LOOP  [SND_NUM] = '{1'b0,     1'b1,     1'b0};

endpackage
`default_nettype wire

// File: rtl/sound_prio_enc.sv
`default_nettype none
// ============================================================================
// sound_prio_enc
//   Combinational highest-set-bit encoder over the pending request vector.
//   Revision: 1.0
// ============================================================================
module sound_prio_enc
   import common_defines::*;
#(
   parameter int NUM_SOUNDS = SND_NUM,
   parameter int ID_W       = 2
) (
   input  logic [NUM_SOUNDS-1:0] i_pending,
   output logic                  o_valid,
   output logic [ID_W-1:0]       o_id
);

   always_comb begin
      o_valid = 1'b0;
      o_id    = '0;
      for (int i = 0; i < NUM_SOUNDS; i++) begin
         if (i_pending[i]) begin
            o_valid = 1'b1;
            o_id    = ID_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// sound_sequencer
//   Latches and prioritises sound requests and plays clips from the shared
//   sample ROM into the PWM stage, one sample per 8 kHz strobe.
//   Revision: 1.0
// ============================================================================
module sound_sequencer
   import common_defines::*;
#(
   parameter int                    ADDR_W     = SND_ADDR_W,
   parameter int                    DATA_W     = SND_DATA_W,
   parameter int                    NUM_SOUNDS = SND_NUM,
   parameter logic [DATA_W-1:0]     IDLE_LEVEL = common_defines::IDLE_LEVEL
) (
   input  logic                  clk_25MHZ,
   input  logic                  rst,
   input  logic                  clk_8KHZ,
   input  logic [NUM_SOUNDS-1:0] sound_req,
   input  logic                  stop,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [DATA_W-1:0]     rom_data,
   output logic [DATA_W-1:0]     sample_out,
   output logic                  en,
   output logic                  busy,
   output logic [1:0]            cur_sound,
   output logic                  done
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   state_t                r_state,    w_state_nxt;
   logic [NUM_SOUNDS-1:0] r_pending,  w_pending_nxt;
   logic [ADDR_W-1:0]     r_rom_addr, w_rom_addr_nxt;
   logic [ADDR_W-1:0]     r_offset,   w_offset_nxt;
   logic [DATA_W-1:0]     r_sample,   w_sample_nxt;
   logic [1:0]            r_cur,      w_cur_nxt;
   logic                  r_done,     w_done_nxt;

   logic [NUM_SOUNDS-1:0] w_req_mask;
   logic [NUM_SOUNDS-1:0] w_pend_eff;
   logic                  w_valid;
   logic [1:0]            w_id;
   logic                  w_last;
   logic                  w_start;

   // A looping siren ignores requests for itself while it plays
   always_comb begin
      w_req_mask = '1;
      if (r_state == ST_PLAY && r_cur == SND_SIREN)
         w_req_mask[SND_SIREN] = 1'b0;
   end

   assign w_pend_eff = r_pending | (sound_req & w_req_mask);
   assign w_last     = (r_offset == ADDR_W'(CLIP_LEN[r_cur]) - ADDR_W'(1));

   sound_prio_enc #(
      .NUM_SOUNDS (NUM_SOUNDS),
      .ID_W       (2)
   ) u_prio_enc (
      .i_pending (w_pend_eff),
      .o_valid   (w_valid),
      .o_id      (w_id)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_pending_nxt  = w_pend_eff;
      w_rom_addr_nxt = r_rom_addr;
      w_offset_nxt   = r_offset;
      w_sample_nxt   = r_sample;
      w_cur_nxt      = r_cur;
      w_done_nxt     = 1'b0;
      w_start        = 1'b0;

      if (stop) begin
         w_state_nxt   = ST_IDLE;
         w_pending_nxt = '0;
         w_sample_nxt  = IDLE_LEVEL;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clk_8KHZ)
                  w_sample_nxt = IDLE_LEVEL;
               w_start = w_valid;
            end
            ST_PLAY: begin
               if (clk_8KHZ) begin
                  w_sample_nxt = rom_data;
                  // Preemption wins over end-of-clip handling
                  if (w_valid && (w_id > r_cur)) begin
                     w_start = 1'b1;
                  end else if (w_last) begin
                     if (CLIP_LOOP[r_cur]) begin
                        w_rom_addr_nxt = ADDR_W'(CLIP_START[r_cur]);
                        w_offset_nxt   = '0;
                     end else if (w_valid) begin
                        w_start = 1'b1;
                     end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                     end
                  end else begin
                     w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
                     w_offset_nxt   = r_offset + ADDR_W'(1);
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase

         if (w_start) begin
            w_state_nxt    = ST_PLAY;
            w_pending_nxt  = w_pend_eff & ~(NUM_SOUNDS'(1) << w_id);
            w_rom_addr_nxt = ADDR_W'(CLIP_START[w_id]);
            w_offset_nxt   = '0;
            w_cur_nxt      = w_id;
         end
      end
   end

   always_ff @(posedge clk_25MHZ) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pending  <= '0;
         r_rom_addr <= '0;
         r_offset   <= '0;
         r_sample   <= IDLE_LEVEL;
         r_cur      <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pending  <= w_pending_nxt;
         r_rom_addr <= w_rom_addr_nxt;
         r_offset   <= w_offset_nxt;
         r_sample   <= w_sample_nxt;
         r_cur      <= w_cur_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign rom_addr   = r_rom_addr;
   assign sample_out = r_sample;
   assign en         = (r_state == ST_PLAY);
   assign busy       = (r_state == ST_PLAY) | (|r_pending);
   assign cur_sound  = r_cur;
   assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sound_sequencer
//   Directed and random stimulus against a clip-level reference model.
//   Revision: 1.0
// ============================================================================
module tb_sound_sequencer;

   localparam int AW = 15;

   logic           clk_25MHZ = 1'b0;
   logic           rst       = 1'b1;
   logic           clk_8KHZ  = 1'b0;
   logic [2:0]     sound_req = 3'b000;
   logic           stop      = 1'b0;
   logic [AW-1:0]  rom_addr;
   logic [7:0]     rom_data  = 8'h00;
   logic [7:0]     sample_out;
   logic           en;
   logic           busy;
   logic [1:0]     cur_sound;
   logic           done;

   always #20 clk_25MHZ = ~clk_25MHZ;

   logic [7:0] rom_mem [0:32767];
   always @(posedge clk_25MHZ) rom_data <= rom_mem[rom_addr];

   sound_sequencer dut (
      .clk_25MHZ  (clk_25MHZ),
      .rst        (rst),
      .clk_8KHZ   (clk_8KHZ),
      .sound_req  (sound_req),
      .stop       (stop),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .sample_out (sample_out),
      .en         (en),
      .busy       (busy),
      .cur_sound  (cur_sound),
      .done       (done)
   );

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   // Clip table: 0=CHOMP, 1=SIREN, 2=DEATH
   int c_start [3] = '{0, 5736, 6760};
   int c_len   [3] = '{5736, 1024, 12000};
   bit c_loop  [3] = '{1'b0, 1'b1, 1'b0};

   // Reference model: playing flag, clip ID, sample index in clip, pending set
   bit       m_play = 1'b0;
   int       m_id   = 0;
   int       m_pos  = 0;
   bit [2:0] m_pend = 3'b000;
   bit [7:0] m_smp  = 8'h80;
   bit       m_done = 1'b0;

   int            done_cnt  = 0;
   int            wrap_cnt  = 0;
   logic [AW-1:0] prev_addr = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic begin_clip(input int id);
      m_pend[id] = 1'b0;
      m_id       = id;
      m_pos      = 0;
      m_play     = 1'b1;
   endtask

   task automatic model_step(input bit r, input bit st, input bit stb, input bit [2:0] rq);
      bit [2:0] eff;
      int       hi;
      m_done = 1'b0;
      if (r) begin
         m_play = 1'b0; m_id = 0; m_pos = 0; m_pend = 3'b000; m_smp = 8'h80;
      end else if (st) begin
         m_play = 1'b0; m_pend = 3'b000; m_smp = 8'h80;
      end else begin
         eff = m_pend | rq;
         if (m_play && m_id == 1) eff[1] = m_pend[1];
         hi = -1;
         for (int i = 0; i < 3; i++) if (eff[i]) hi = i;
         m_pend = eff;
         if (!m_play) begin
            if (stb) m_smp = 8'h80;
            if (hi >= 0) begin_clip(hi);
         end else if (stb) begin
            m_smp = rom_mem[c_start[m_id] + m_pos];
            if (hi > m_id) begin_clip(hi);
            else if (m_pos == c_len[m_id] - 1) begin
               if (c_loop[m_id])  m_pos = 0;
               else if (hi >= 0)  begin_clip(hi);
               else begin m_play = 1'b0; m_done = 1'b1; end
            end else m_pos++;
         end
      end
   endtask

   task automatic tick(input bit [2:0] rq, input bit st, input bit stb);
      sound_req = rq;
      stop      = st;
      clk_8KHZ  = stb;
      @(posedge clk_25MHZ);
      model_step(rst, st, stb, rq);
      #1;
      chk("sample_out", 32'(sample_out), 32'(m_smp));
      chk("en",         32'(en),         32'(m_play));
      chk("busy",       32'(busy),       32'(m_play || (m_pend != 3'b000)));
      chk("done",       32'(done),       32'(m_done));
      if (m_play) begin
         chk("rom_addr",  32'(rom_addr),  32'(c_start[m_id] + m_pos));
         chk("cur_sound", 32'(cur_sound), 32'(m_id));
      end
      if (done) done_cnt++;
      if (prev_addr == AW'(6759) && rom_addr == AW'(5736)) wrap_cnt++;
      prev_addr = rom_addr;
   endtask

   // One strobe, a request slot right after it, then idle cycles
   task automatic strobe(input bit [2:0] rq, input bit st);
      tick(3'b000, 1'b0, 1'b1);
      tick(rq, st, 1'b0);
      tick(3'b000, 1'b0, 1'b0);
      if ($urandom_range(0, 15) == 0) tick(3'b000, 1'b0, 1'b0);
   endtask

   task automatic run(input int n);
      repeat (n) strobe(3'b000, 1'b0);
   endtask

   initial begin
      bit [2:0] rq;
      bit       st;

      for (int i = 0; i < 32768; i++) rom_mem[i] = 8'($urandom);

      // Reset and silent idle
      rst = 1'b1;
      tick(3'b000, 1'b0, 1'b0);
      tick(3'b000, 1'b0, 1'b1);
      chk("rst_rom_addr",  32'(rom_addr),  32'd0);
      chk("rst_cur_sound", 32'(cur_sound), 32'd0);
      chk("rst_sample",    32'(sample_out), 32'h80);
      rst = 1'b0;
      run(10);
      chk("idle_rom_addr", 32'(rom_addr), 32'd0);

      // CHOMP one-shot from idle
      done_cnt = 0;
      tick(3'b000, 1'b0, 1'b1);
      tick(3'b001, 1'b0, 1'b0);
      chk("chomp_start_addr", 32'(rom_addr), 32'd0);
      chk("chomp_start_en",   32'(en),       32'd1);
      tick(3'b000, 1'b0, 1'b0);
      run(5736);
      chk("chomp_done_cnt", 32'(done_cnt), 32'd1);
      chk("chomp_end_en",   32'(en),       32'd0);
      run(1);
      chk("chomp_idle_smp", 32'(sample_out), 32'h80);

      // SIREN loops once across its end, own re-request dropped
      done_cnt = 0;
      wrap_cnt = 0;
      strobe(3'b010, 1'b0);
      run(500);
      strobe(3'b010, 1'b0);
      run(529);
      chk("siren_wraps",    32'(wrap_cnt), 32'd1);
      chk("siren_no_done",  32'(done_cnt), 32'd0);
      chk("siren_en",       32'(en),       32'd1);

      // DEATH preempts SIREN; CHOMP requested twice while DEATH plays
      done_cnt = 0;
      strobe(3'b100, 1'b0);
      run(1);
      chk("death_addr", 32'(rom_addr),  32'd6760);
      chk("death_cur",  32'(cur_sound), 32'd2);
      strobe(3'b001, 1'b0);
      run(100);
      strobe(3'b001, 1'b0);
      chk("death_busy", 32'(busy), 32'd1);
      run(11898);
      chk("chomp_follow_addr", 32'(rom_addr),  32'd0);
      chk("chomp_follow_cur",  32'(cur_sound), 32'd0);
      chk("death_no_done",     32'(done_cnt),  32'd0);
      run(5736);
      chk("chomp2_done_cnt", 32'(done_cnt), 32'd1);
      run(3);
      chk("no_resume_en",   32'(en),   32'd0);
      chk("no_resume_busy", 32'(busy), 32'd0);

      // Stop mid-clip with a simultaneous DEATH request
      done_cnt = 0;
      strobe(3'b010, 1'b0);
      run(40);
      tick(3'b000, 1'b0, 1'b1);
      tick(3'b100, 1'b1, 1'b0);
      chk("stop_en",   32'(en),         32'd0);
      chk("stop_busy", 32'(busy),       32'd0);
      chk("stop_smp",  32'(sample_out), 32'h80);
      tick(3'b000, 1'b0, 1'b0);
      run(20);
      chk("stop_no_done", 32'(done_cnt), 32'd0);
      chk("stop_idle_en", 32'(en),       32'd0);

      // Random requests and occasional stops
      repeat (400) begin
         rq = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) rq = 3'b000;
         st = ($urandom_range(0, 40) == 0);
         strobe(rq, st);
      end

      // Reset in mid-clip
      strobe(3'b001, 1'b0);
      run(30);
      rst = 1'b1;
      tick(3'b000, 1'b0, 1'b0);
      chk("mrst_rom_addr", 32'(rom_addr),  32'd0);
      chk("mrst_cur",      32'(cur_sound), 32'd0);
      rst = 1'b0;
      run(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
